// File: rtl/udma_uart_rx.sv
// udma_uart_rx: serial receive half of the uDMA UART.
// Synchronises rx_i, detects the start edge, samples each bit mid-period using
// a (cfg_div_i+1)-clock bit period, and hands 5..8 bit characters to the uDMA
// RX channel over a valid/ready handshake. Parity, framing and overflow errors
// are reported as registered single-cycle pulses.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   rx_i                    asynchronous serial line, idle high
//   busy_o                  receiver is inside a frame (FSM not idle)
//   cfg_en_i                receiver enable; low abandons any frame
//   cfg_div_i               bit period minus one, in clocks (>= 3)
//   cfg_parity_en_i         even parity bit follows the data bits
//   cfg_bits_i              data bits minus five
//   rx_data_o, rx_valid_o   received character and its valid flag
//   rx_ready_i              consumer accepts rx_data_o
//   err_parity_o            parity mismatch on a delivered character
//   err_frame_o             stop bit sampled low, character discarded
//   err_overflow_o          character dropped while rx_valid_o was held
module udma_uart_rx (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        busy_o,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_bits_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        err_parity_o,
    output logic        err_frame_o,
    output logic        err_overflow_o
);

    localparam int unsigned DIV_W     = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic                   par_acc_q, par_acc_d;
    logic                   par_err_q, par_err_d;
    logic [1:0]             rx_sync_q;
    logic                   rx_prev_q;

    logic                   busy_d;
    logic [DATA_W-1:0]      rx_data_d;
    logic                   rx_valid_d;
    logic                   err_parity_d;
    logic                   err_frame_d;
    logic                   err_overflow_d;

    logic                   rx_s;
    logic                   fall_edge;
    logic                   last_bit;

    assign rx_s      = rx_sync_q[1];
    // A held-low line never shows a new falling edge, so a break yields one frame error only.
    assign fall_edge = rx_prev_q & ~rx_s;
    assign last_bit  = (bit_cnt_q == (BIT_CNT_W'(cfg_bits_i) + BIT_CNT_W'(4)));

    // State, datapath and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_sync_q      <= '1;
            rx_prev_q      <= 1'b1;
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            par_acc_q      <= 1'b0;
            par_err_q      <= 1'b0;
            busy_o         <= 1'b0;
            rx_data_o      <= '0;
            rx_valid_o     <= 1'b0;
            err_parity_o   <= 1'b0;
            err_frame_o    <= 1'b0;
            err_overflow_o <= 1'b0;
        end else begin
            rx_sync_q      <= {rx_sync_q[0], rx_i};
            rx_prev_q      <= rx_s;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            par_acc_q      <= par_acc_d;
            par_err_q      <= par_err_d;
            busy_o         <= busy_d;
            rx_data_o      <= rx_data_d;
            rx_valid_o     <= rx_valid_d;
            err_parity_o   <= err_parity_d;
            err_frame_o    <= err_frame_d;
            err_overflow_o <= err_overflow_d;
        end
    end

    // Next-state, bit sampling and output decisions
    always_comb begin
        state_d        = state_q;
        cnt_d          = (state_q == ST_IDLE) ? '0 : cnt_q + DIV_W'(1);
        bit_cnt_d      = bit_cnt_q;
        shreg_d        = shreg_q;
        par_acc_d      = par_acc_q;
        par_err_d      = par_err_q;
        rx_data_d      = rx_data_o;
        rx_valid_d     = rx_valid_o & ~rx_ready_i;
        err_parity_d   = 1'b0;
        err_frame_d    = 1'b0;
        err_overflow_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall_edge && cfg_en_i) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == (cfg_div_i >> 1)) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                        par_acc_d = 1'b0;
                        par_err_d = 1'b0;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == cfg_div_i) begin
                    cnt_d              = '0;
                    shreg_d[bit_cnt_q] = rx_s;
                    par_acc_d          = par_acc_q ^ rx_s;
                    if (last_bit) begin
                        state_d = cfg_parity_en_i ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q == cfg_div_i) begin
                    par_err_d = rx_s ^ par_acc_q;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == cfg_div_i) begin
                    state_d = ST_IDLE;
                    if (!rx_s) begin
                        err_frame_d = 1'b1;
                    end else if (!rx_valid_o || rx_ready_i) begin
                        // A same-cycle consume frees the slot, so no overflow.
                        rx_data_d    = shreg_q;
                        rx_valid_d   = 1'b1;
                        err_parity_d = par_err_q;
                    end else begin
                        err_overflow_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Disable abandons the frame silently and drops any held character.
        if (!cfg_en_i) begin
            state_d        = ST_IDLE;
            cnt_d          = '0;
            rx_valid_d     = 1'b0;
            err_parity_d   = 1'b0;
            err_frame_d    = 1'b0;
            err_overflow_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

endmodule
